// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and owner index; the owner holds until it drops req, en falls or MAX_HOLD expires.
// Latency: req sampled at edge t gives gnt after edge t; every release inserts one idle cycle. No backpressure, req is level-sensitive.
module rr_onehot_arbiter #(
    parameter int N        = 8,
    parameter int IW       = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          busy,
    output logic          timeout
);

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, ptr_nx;
    logic [IW-1:0] idx_nx;
    logic [IW-1:0] win, cand;
    logic          found;
    logic          hold_exp;
    logic [N-1:0]  gnt_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          tmo_nx;

    // Scan ptr+1, ptr+2, ... ; the IW-bit add wraps N-1 -> 0 because N = 2**IW.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ptr + IW'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign hold_exp = (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD));

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        idx_nx   = gnt_idx;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        tmo_nx   = 1'b0;
        case (state)
            IDLE: begin
                gnt_nx = '0;
                if (en && found) begin
                    gnt_nx   = {{(N-1){1'b0}}, 1'b1} << win;
                    idx_nx   = win;
                    cnt_nx   = CW'(1);
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!en || !req[gnt_idx] || hold_exp) begin
                    gnt_nx   = '0;
                    ptr_nx   = gnt_idx;
                    state_nx = IDLE;
                    // Only a forced revoke pulses timeout; en/req drops take priority.
                    tmo_nx   = en && req[gnt_idx];
                end else if (!(MAX_HOLD == 0 && cnt == '1)) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                gnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            timeout <= 1'b0;
            ptr     <= IW'(N - 1);
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            gnt_idx <= idx_nx;
            timeout <= tmo_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
        end
    end

    assign busy = |gnt;

endmodule
